io_buffer_controller: RTL and testbench

- Sequences the UART resources behind the ININT/INFLT/OUT instructions.
- RX path: assembles incoming bytes into 32-bit words and buffers them for the core.
- TX path: queues OUT bytes and drives the UART transmitter.
- Produces the in_busy/out_busy flags that the stall logic consumes to hold the pc and phases.

---
 rtl/io_buffer_controller_pkg.sv | 15 +
 rtl/io_buffer_controller_sync_fifo.sv | 46 ++++
 rtl/io_buffer_controller.sv | 117 +++++++++++
 tb/tb_io_buffer_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_buffer_controller_pkg.sv
// Shared widths, default FIFO depths and the TX sequencer state encoding
// used by the I/O buffer controller and its FIFOs.
package io_params;
  localparam int BYTE_W              = 8;
  localparam int WORD_W              = 32;
  localparam int IN_DEPTH_LOG2_DEF   = 4;
  localparam int OUT_DEPTH_LOG2_DEF  = 4;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_GUARD  = 2'd2,
    TX_DRAIN  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/io_buffer_controller_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop on empty is ignored and a
// push on full is accepted only when a pop frees a slot in the same edge.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                 (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end
endmodule

// File: rtl/io_buffer_controller.sv
// UART-side buffering for the ININT/INFLT/OUT instructions: RX bytes are packed
// big-endian into words, OUT bytes are queued and launched one at a time.
module io_buffer_controller
  import io_params::*;
#(
  parameter int IN_DEPTH_LOG2  = IN_DEPTH_LOG2_DEF,
  parameter int OUT_DEPTH_LOG2 = OUT_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              in_req,
  output logic [WORD_W-1:0] in_data,
  output logic              in_busy,
  input  logic              out_req,
  input  logic [BYTE_W-1:0] out_data,
  output logic              out_busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              rx_overrun,
  output tx_state_e         dbg_tx_state
);
  logic [1:0]            r_byte_cnt;
  logic [WORD_W-9:0]     r_shift;
  logic                  r_overrun;
  tx_state_e             r_state;
  logic                  r_tx_start;
  logic [BYTE_W-1:0]     r_tx_data;

  logic                  w_rx_push;
  logic [WORD_W-1:0]     w_rx_word;
  logic [WORD_W-1:0]     w_rx_head;
  logic                  w_rx_empty;
  logic                  w_rx_full;
  logic                  w_tx_pop;
  logic [BYTE_W-1:0]     w_tx_head;
  logic                  w_tx_empty;
  logic                  w_tx_full;

  assign w_rx_push = rx_valid && (r_byte_cnt == 2'd3);
  assign w_rx_word = {r_shift, rx_data};

  sync_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(IN_DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_rx_push),
    .push_data (w_rx_word),
    .pop       (in_req),
    .head      (w_rx_head),
    .empty     (w_rx_empty),
    .full      (w_rx_full)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(OUT_DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (out_req),
    .push_data (out_data),
    .pop       (w_tx_pop),
    .head      (w_tx_head),
    .empty     (w_tx_empty),
    .full      (w_tx_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (rx_valid) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {r_shift[WORD_W-17:0], rx_data};
      end
      // When full the FIFO is non-empty, so in_req alone means a slot frees up.
      if (w_rx_push && w_rx_full && !in_req) r_overrun <= 1'b1;
    end
  end

  // Handshake: a byte leaves the TX FIFO only in IDLE with tx_busy low; it is
  // presented on tx_data with a one-cycle tx_start, then tx_busy is ignored for
  // one GUARD cycle and waited on in DRAIN.
  assign w_tx_pop = (r_state == TX_IDLE) && !w_tx_empty && !tx_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= TX_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_data  <= w_tx_head;
            r_tx_start <= 1'b1;
            r_state    <= TX_LAUNCH;
          end
        end
        TX_LAUNCH: r_state <= TX_GUARD;
        TX_GUARD:  r_state <= TX_DRAIN;
        TX_DRAIN:  if (!tx_busy) r_state <= TX_IDLE;
        default:   r_state <= TX_IDLE;
      endcase
    end
  end

  assign in_data      = w_rx_empty ? '0 : w_rx_head;
  assign in_busy      = w_rx_empty;
  assign out_busy     = w_tx_full;
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign rx_overrun   = r_overrun;
  assign dbg_tx_state = r_state;
endmodule

// File: tb/tb_io_buffer_controller.sv
// Directed bench for io_buffer_controller: word assembly, RX overrun and
// simultaneous push/pop, TX launch sequencing, TX full, asynchronous reset.
module tb_io_buffer_controller;
  import io_params::*;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        in_req;
  logic [31:0] in_data;
  logic        in_busy;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rx_overrun;
  tx_state_e   dbg_tx_state;

  int n_vec;
  int n_err;
  int cyc;

  logic        force_busy;
  logic        model_en;
  int          busy_cnt;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_b[$];

  io_buffer_controller dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .in_req       (in_req),
    .in_data      (in_data),
    .in_busy      (in_busy),
    .out_req      (out_req),
    .out_data     (out_data),
    .out_busy     (out_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_overrun   (rx_overrun),
    .dbg_tx_state (dbg_tx_state)
  );

  // Clock / reset infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy rises the cycle after tx_start, stays 10 cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)                    busy_cnt <= 0;
    else if (model_en && tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0)       busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #7;
    rstn = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  function automatic logic [31:0] mk_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, b ^ 8'hA5, b + 8'h3C, ~b};
  endfunction

  task automatic drain_rx(input string tag);
    logic [31:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (in_busy !== 1'b0 || in_data !== e) begin
        n_err++;
        $display("FAIL %s readback: in_busy=%b in_data=%h expected in_busy=0 in_data=%h",
                 tag, in_busy, in_data, e);
      end
      in_req = 1'b1;
      tick();
      in_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rx_valid = 1'b1; rx_data = 8'hEE; out_req = 1'b1; out_data = 8'h11;
    tick();
    rstn = 1'b0;
    #1;
    rx_valid = 1'b0; out_req = 1'b0;
    n_vec++;
    if (in_busy !== 1'b1 || out_busy !== 1'b0 || in_data !== 32'h0 ||
        tx_start !== 1'b0 || tx_data !== 8'h00 || rx_overrun !== 1'b0 ||
        dbg_tx_state !== TX_IDLE) begin
      n_err++;
      $display("FAIL reset_state: in_busy=%b out_busy=%b in_data=%h tx_start=%b tx_data=%h ovr=%b st=%0d expected 1 0 0 0 0 0 0",
               in_busy, out_busy, in_data, tx_start, tx_data, rx_overrun, dbg_tx_state);
    end
    #5;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_assembly();
    logic [7:0] bytes [4];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (in_busy !== 1'b1) begin
        n_err++;
        $display("FAIL asm_busy_before_byte%0d: in_busy=%b expected 1", i, in_busy);
      end
      send_byte(bytes[i]);
      if (i != 3) begin tick(); tick(); end
    end
    n_vec++;
    if (in_busy !== 1'b0 || in_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL asm_word: in_busy=%b in_data=%h expected 0 12345678", in_busy, in_data);
    end
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    n_vec++;
    if (in_busy !== 1'b1) begin
      n_err++;
      $display("FAIL asm_pop: in_busy=%b expected 1", in_busy);
    end
  endtask

  task automatic test_rx_overrun();
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 17; k++) begin
      send_word(mk_word(k));
      if (k < 16) exp_q.push_back(mk_word(k));
      if (k == 15) begin
        n_vec++;
        if (rx_overrun !== 1'b0) begin
          n_err++;
          $display("FAIL ovr_at_16: rx_overrun=%b expected 0", rx_overrun);
        end
      end
    end
    n_vec++;
    if (rx_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_at_17: rx_overrun=%b expected 1", rx_overrun);
    end
    drain_rx("ovr");
    n_vec++;
    if (in_busy !== 1'b1 || rx_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_after_drain: in_busy=%b rx_overrun=%b expected 1 1", in_busy, rx_overrun);
    end
    do_reset();
    n_vec++;
    if (rx_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_cleared: rx_overrun=%b expected 0", rx_overrun);
    end
  endtask

  task automatic test_rx_full_simul();
    logic [31:0] w;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      send_word(mk_word(k + 32));
      exp_q.push_back(mk_word(k + 32));
    end
    w = 32'hCAFE_F00D;
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    n_vec++;
    if (in_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL simul_head: in_data=%h expected %h", in_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(w);
    rx_data = w[7:0]; rx_valid = 1'b1; in_req = 1'b1;
    tick();
    rx_valid = 1'b0; in_req = 1'b0;
    n_vec++;
    if (rx_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL simul_overrun: rx_overrun=%b expected 0", rx_overrun);
    end
    drain_rx("simul");
    n_vec++;
    if (in_busy !== 1'b1) begin
      n_err++;
      $display("FAIL simul_empty_after_16: in_busy=%b expected 1", in_busy);
    end
  endtask

  task automatic test_tx_sequence();
    int starts;
    int last_start;
    do_reset();
    model_en = 1'b1;
    out_req = 1'b1; out_data = 8'hA5;
    tick();
    out_data = 8'h5A;
    tick();
    out_req = 1'b0;
    n_vec++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      n_err++;
      $display("FAIL tx_first_start: tx_start=%b tx_data=%h expected 1 a5", tx_start, tx_data);
    end
    starts = 1;
    last_start = 2;
    for (int c = 3; c < 40; c++) begin
      tick();
      if (tx_start === 1'b1) begin
        starts++;
        n_vec++;
        if (c != 15 || tx_data !== 8'h5A || c - last_start < 4) begin
          n_err++;
          $display("FAIL tx_second_start: cycle=%0d tx_data=%h expected cycle 15 data 5a", c, tx_data);
        end
        last_start = c;
      end
    end
    n_vec++;
    if (starts != 2) begin
      n_err++;
      $display("FAIL tx_start_count: got %0d expected 2", starts);
    end
    model_en = 1'b0;
  endtask

  task automatic test_tx_full();
    int starts;
    int last_start;
    do_reset();
    exp_b.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      out_req = 1'b1; out_data = 8'h30 + 8'(i);
      if (i < 16) exp_b.push_back(8'h30 + 8'(i));
      tick();
      out_req = 1'b0;
      if (i == 14 || i == 15) begin
        n_vec++;
        if (out_busy !== (i == 15)) begin
          n_err++;
          $display("FAIL txfull_busy_after_%0d: out_busy=%b expected %b", i + 1, out_busy, i == 15);
        end
      end
    end
    force_busy = 1'b0;
    starts = 0;
    last_start = -10;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (tx_start === 1'b1) begin
        starts++;
        n_vec++;
        if (exp_b.size() == 0 || tx_data !== exp_b[0] || c - last_start < 4) begin
          n_err++;
          $display("FAIL txfull_order: start %0d tx_data=%h expected %h (gap %0d)",
                   starts, tx_data, exp_b.size() ? exp_b[0] : 8'hxx, c - last_start);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
        last_start = c;
      end
    end
    n_vec++;
    if (starts != 16 || out_busy !== 1'b0) begin
      n_err++;
      $display("FAIL txfull_count: starts=%0d out_busy=%b expected 16 0", starts, out_busy);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    out_req = 1'b1; out_data = 8'h77;
    tick();
    out_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (tx_start === 1'b1) seen = 1;
      else tick();
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL async_launch_timeout: tx_start never rose within 10 cycles");
    end
    #2;
    rstn = 1'b0;
    #1;
    n_vec++;
    if (tx_start !== 1'b0 || dbg_tx_state !== TX_IDLE || tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL async_launch_drop: tx_start=%b st=%0d tx_data=%h expected 0 0 00",
               tx_start, dbg_tx_state, tx_data);
    end
    #3;
    rstn = 1'b1;
    tick();
    send_byte(8'hDE);
    send_byte(8'hAD);
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    tick();
    send_word(32'h0BAD_CAFE);
    n_vec++;
    if (in_busy !== 1'b0 || in_data !== 32'h0BADCAFE) begin
      n_err++;
      $display("FAIL async_partial_discard: in_busy=%b in_data=%h expected 0 0badcafe", in_busy, in_data);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rstn = 1'b1; rx_data = '0; rx_valid = 1'b0; in_req = 1'b0;
    out_req = 1'b0; out_data = '0; force_busy = 1'b0; model_en = 1'b0;
    tick();
    test_reset();
    test_assembly();
    test_rx_overrun();
    test_rx_full_simul();
    test_tx_sequence();
    test_tx_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
